// File: rtl/dm_bridge_pkg.sv
// dm_bridge_pkg: shared definitions for the debug-module core bridge.
//   - DMI register addresses decoded by dm_core_bridge
//   - bridge FSM state enum
//   - dmcontrol / dmstatus / dbgcs bit positions
package dm_bridge_pkg;

   localparam logic [6:0] DMI_DMCONTROL = 7'h10;
   localparam logic [6:0] DMI_DMSTATUS  = 7'h11;
   localparam logic [6:0] DMI_DBGCS     = 7'h38;
   localparam logic [6:0] DMI_DBGADDR   = 7'h39;
   localparam logic [6:0] DMI_DBGDATA   = 7'h3C;

   localparam int DMCONTROL_HALTREQ   = 31;
   localparam int DMCONTROL_RESUMEREQ = 30;
   localparam int DMCONTROL_DMACTIVE  = 0;

   localparam int DMSTATUS_ALLRUNNING    = 11;
   localparam int DMSTATUS_ALLHALTED     = 9;
   localparam int DMSTATUS_AUTHENTICATED = 7;
   localparam logic [3:0] DMSTATUS_VERSION = 4'd2;

   localparam int DBGCS_ERR  = 12;
   localparam int DBGCS_BUSY = 21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } dm_state_e;

endpackage

// File: rtl/dm_timeout_counter.sv
// dm_timeout_counter: cycle counter that flags the last allowed cycle of a wait.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count at 0 on the next edge (state entry)
//   enable     : count this cycle
//   expired    : this enabled cycle is cycle LIMIT-1 of the wait
module dm_timeout_counter #(
   parameter int LIMIT = 64,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LAST)) begin
         // Saturate so a stuck enable can never wrap back into range.
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/dm_core_bridge.sv
// dm_core_bridge: DMI register front end for the zeroriscy core debug port.
// Decodes dmcontrol/dmstatus/dbgcs/dbgaddr/dbgdata; a dbgdata access runs a
// req/gnt/rvalid transaction on the core debug bus, aborted after
// TIMEOUT_CYCLES cycles of waiting for gnt or for rvalid.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   dmi_*                      : DMI request (valid held until ready) / response
//   debug_req/gnt/rvalid/...   : core debug bus
//   debug_halted_i             : core halted status
//   debug_halt_o/resume_o      : one-cycle run-control pulses
// DMI handshake: dmi_valid_i is held with stable addr/we/wdata until
// dmi_ready_o, a one-cycle strobe during which dmi_rdata_o is valid; a new
// request is accepted no earlier than the cycle after the strobe.
// Build option: define DM_AUTOINC_EN to post-increment dbgaddr by 4 after
// every successful dbgdata access.
module dm_core_bridge
   import dm_bridge_pkg::*;
#(
   parameter int DBG_ADDR_WIDTH = 15,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      dmi_valid_i,
   output logic                      dmi_ready_o,
   input  logic [6:0]                dmi_addr_i,
   input  logic                      dmi_write_en_i,
   input  logic [31:0]               dmi_wdata_i,
   output logic [31:0]               dmi_rdata_o,
   output logic                      debug_req_o,
   input  logic                      debug_gnt_i,
   input  logic                      debug_rvalid_i,
   output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
   output logic                      debug_we_o,
   output logic [31:0]               debug_wdata_o,
   input  logic [31:0]               debug_rdata_i,
   input  logic                      debug_halted_i,
   output logic                      debug_halt_o,
   output logic                      debug_resume_o
);

   dm_state_e state_q, state_d;

   logic                      dmactive_q, err_q, halt_q, resume_q;
   logic [DBG_ADDR_WIDTH-1:0] dbgaddr_q, core_addr_q;
   logic                      core_we_q;
   logic [31:0]               core_wdata_q, rdata_q, reg_rdata;
   logic                      core_go, to_clear, to_enable, to_expired;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      // Blocked dbgdata accesses (inactive or err set) fall through to a
      // plain register completion with read data 0.
      core_go = dmi_valid_i && (dmi_addr_i == DMI_DBGDATA) && dmactive_q && !err_q;
      case (state_q)
         ST_IDLE: if (dmi_valid_i) state_d = core_go ? ST_REQ : ST_RESP;
         ST_REQ:  if (debug_gnt_i) state_d = ST_WAIT;
                  else if (to_expired) state_d = ST_RESP;
         ST_WAIT: if (debug_rvalid_i || to_expired) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Counter restarts on every state change; counts only while waiting.
      to_clear  = (state_d != state_q);
      to_enable = (state_q == ST_REQ) || (state_q == ST_WAIT);
   end

   dm_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES),
      .WIDTH (TO_CNT_WIDTH)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (to_expired)
   );

   // ---------------- register read mux ----------------
   always_comb begin
      reg_rdata = '0;
      case (dmi_addr_i)
         DMI_DMCONTROL: reg_rdata[DMCONTROL_DMACTIVE] = dmactive_q;
         // dmstatus stays readable while inactive so the host can probe the DM.
         DMI_DMSTATUS: begin
            reg_rdata[DMSTATUS_ALLHALTED]     = debug_halted_i;
            reg_rdata[DMSTATUS_ALLRUNNING]    = ~debug_halted_i;
            reg_rdata[DMSTATUS_AUTHENTICATED] = 1'b1;
            reg_rdata[3:0]                    = DMSTATUS_VERSION;
         end
         DMI_DBGCS:   if (dmactive_q) reg_rdata[DBGCS_ERR] = err_q;
         DMI_DBGADDR: if (dmactive_q) reg_rdata[DBG_ADDR_WIDTH-1:0] = dbgaddr_q;
         default:     reg_rdata = '0;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmactive_q   <= 1'b0;
         err_q        <= 1'b0;
         halt_q       <= 1'b0;
         resume_q     <= 1'b0;
         dbgaddr_q    <= '0;
         core_addr_q  <= '0;
         core_we_q    <= 1'b0;
         core_wdata_q <= '0;
         rdata_q      <= '0;
      end else begin
         halt_q   <= 1'b0;
         resume_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (core_go) begin
                  core_addr_q  <= dbgaddr_q;
                  core_we_q    <= dmi_write_en_i;
                  core_wdata_q <= dmi_wdata_i;
               end else if (dmi_valid_i) begin
                  rdata_q <= dmi_write_en_i ? 32'h0 : reg_rdata;
                  if (dmi_write_en_i) begin
                     case (dmi_addr_i)
                        DMI_DMCONTROL: begin
                           dmactive_q <= dmi_wdata_i[DMCONTROL_DMACTIVE];
                           // Halt has priority over resume.
                           halt_q   <= dmi_wdata_i[DMCONTROL_HALTREQ];
                           resume_q <= dmi_wdata_i[DMCONTROL_RESUMEREQ] &&
                                       !dmi_wdata_i[DMCONTROL_HALTREQ];
                           if (!dmi_wdata_i[DMCONTROL_DMACTIVE]) begin
                              dbgaddr_q <= '0;
                              err_q     <= 1'b0;
                           end
                        end
                        DMI_DBGCS:
                           if (dmactive_q && dmi_wdata_i[DBGCS_ERR]) err_q <= 1'b0;
                        DMI_DBGADDR:
                           if (dmactive_q) dbgaddr_q <= dmi_wdata_i[DBG_ADDR_WIDTH-1:0];
                        default: ;
                     endcase
                  end
               end
            end
            ST_REQ: begin
               if (!debug_gnt_i && to_expired) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
               end
            end
            ST_WAIT: begin
               if (debug_rvalid_i) begin
                  rdata_q <= core_we_q ? 32'h0 : debug_rdata_i;
`ifdef DM_AUTOINC_EN
                  dbgaddr_q <= dbgaddr_q + DBG_ADDR_WIDTH'(4);
`endif
               end else if (to_expired) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmi_ready_o    = (state_q == ST_RESP);
   assign dmi_rdata_o    = dmi_ready_o ? rdata_q : 32'h0;
   assign debug_req_o    = (state_q == ST_REQ);
   assign debug_addr_o   = core_addr_q;
   assign debug_we_o     = core_we_q;
   assign debug_wdata_o  = core_wdata_q;
   assign debug_halt_o   = halt_q;
   assign debug_resume_o = resume_q;

endmodule

// File: tb/tb_dm_core_bridge.sv
// tb_dm_core_bridge: directed bench for dm_core_bridge with a transaction-level
// model of the DMI register map and core-bus timing.
module tb_dm_core_bridge;

   localparam int TO = 64;
   localparam logic [31:0] ADDR_MASK = 32'h0000_7FFF;
   localparam logic [6:0] A_CTRL = 7'h10, A_STAT = 7'h11, A_CS = 7'h38,
                          A_ADDR = 7'h39, A_DATA = 7'h3C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dmi_valid_i = 1'b0, dmi_write_en_i = 1'b0;
   logic [6:0]  dmi_addr_i = '0;
   logic [31:0] dmi_wdata_i = '0, debug_rdata_i = '0;
   logic        debug_gnt_i = 1'b0, debug_rvalid_i = 1'b0, debug_halted_i = 1'b0;
   logic        dmi_ready_o, debug_req_o, debug_we_o, debug_halt_o, debug_resume_o;
   logic [31:0] dmi_rdata_o, debug_wdata_o;
   logic [14:0] debug_addr_o;

   dm_core_bridge #(.DBG_ADDR_WIDTH(15), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .dmi_valid_i(dmi_valid_i), .dmi_ready_o(dmi_ready_o), .dmi_addr_i(dmi_addr_i),
      .dmi_write_en_i(dmi_write_en_i), .dmi_wdata_i(dmi_wdata_i), .dmi_rdata_o(dmi_rdata_o),
      .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i),
      .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o), .debug_wdata_o(debug_wdata_o),
      .debug_rdata_i(debug_rdata_i), .debug_halted_i(debug_halted_i),
      .debug_halt_o(debug_halt_o), .debug_resume_o(debug_resume_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          req;
      int          halt;
      int          resume;
      logic [31:0] caddr;
      logic        cwe;
      logic [31:0] cwdata;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, failures = 0;
   logic [31:0] last_rdata;
   int last_lat, last_req, last_halt, last_resume;

   // model state
   logic        m_act = 1'b0, m_err = 1'b0;
   logic [31:0] m_dbgaddr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outcome of one DMI access from the register map and wait-time rules.
   // gnt_at: req cycle (1-based) on which the core grants, 0 = never.
   // rv_after: cycles after the grant cycle until rvalid, 0 = never.
   function automatic exp_t model_access(input logic [6:0] addr, input logic we,
                                         input logic [31:0] wdata, input int gnt_at,
                                         input int rv_after, input logic [31:0] core_rd);
      exp_t e;
      e.rdata = 32'h0; e.lat = 1; e.req = 0; e.halt = 0; e.resume = 0;
      e.caddr = 32'h0; e.cwe = 1'b0; e.cwdata = 32'h0;
      if (addr == A_DATA) begin
         if (m_act && !m_err) begin
            e.caddr = m_dbgaddr; e.cwe = we; e.cwdata = wdata;
            if (gnt_at < 1 || gnt_at > TO) begin
               e.req = TO; e.lat = TO + 1; m_err = 1'b1;
            end else begin
               e.req = gnt_at;
               if (rv_after < 1 || rv_after > TO) begin
                  e.lat = gnt_at + TO + 1; m_err = 1'b1;
               end else begin
                  e.lat = gnt_at + rv_after + 1;
                  e.rdata = we ? 32'h0 : core_rd;
`ifdef DM_AUTOINC_EN
                  m_dbgaddr = (m_dbgaddr + 32'd4) & ADDR_MASK;
`endif
               end
            end
         end
      end else if (we) begin
         if (addr == A_CTRL) begin
            e.halt = wdata[31] ? 1 : 0;
            e.resume = (wdata[30] && !wdata[31]) ? 1 : 0;
            if (!wdata[0]) begin m_dbgaddr = 32'h0; m_err = 1'b0; end
            m_act = wdata[0];
         end else if (addr == A_CS && m_act && wdata[12]) m_err = 1'b0;
         else if (addr == A_ADDR && m_act) m_dbgaddr = wdata & ADDR_MASK;
      end else begin
         case (addr)
            A_CTRL: e.rdata = {31'h0, m_act};
            A_STAT: e.rdata = (debug_halted_i ? 32'h200 : 32'h800) | 32'h80 | 32'h2;
            A_CS:   e.rdata = m_act ? {19'h0, m_err, 12'h0} : 32'h0;
            A_ADDR: e.rdata = m_act ? m_dbgaddr : 32'h0;
            default: e.rdata = 32'h0;
         endcase
      end
      return e;
   endfunction

   // ---------------- compare process ----------------
   int txn_cyc = 0, req_cnt = 0, halt_cnt = 0, resume_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         txn_cyc = 0; req_cnt = 0; halt_cnt = 0; resume_cnt = 0;
      end else if (dmi_valid_i) begin
         if (debug_req_o) begin
            req_cnt++;
            if (exp_q.size() > 0) begin
               check("core_addr", {17'h0, debug_addr_o}, exp_q[0].caddr);
               check("core_we", {31'h0, debug_we_o}, {31'h0, exp_q[0].cwe});
               check("core_wdata", debug_wdata_o, exp_q[0].cwdata);
            end
         end
         halt_cnt += int'(debug_halt_o);
         resume_cnt += int'(debug_resume_o);
         if (dmi_ready_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("rdata", dmi_rdata_o, e.rdata);
               check("latency", 32'(txn_cyc), 32'(e.lat));
               check("req_cycles", 32'(req_cnt), 32'(e.req));
               check("halt_pulses", 32'(halt_cnt), 32'(e.halt));
               check("resume_pulses", 32'(resume_cnt), 32'(e.resume));
            end
            last_rdata = dmi_rdata_o; last_lat = txn_cyc; last_req = req_cnt;
            last_halt = halt_cnt; last_resume = resume_cnt;
            txn_cyc = 0; req_cnt = 0; halt_cnt = 0; resume_cnt = 0;
         end else begin
            txn_cyc++;
         end
      end else begin
         if (dmi_ready_o) check("spurious_ready", 32'h1, 32'h0);
         if (debug_halt_o || debug_resume_o) check("spurious_pulse", 32'h1, 32'h0);
         txn_cyc = 0; req_cnt = 0; halt_cnt = 0; resume_cnt = 0;
      end
   end

   // ---------------- driver ----------------
   task automatic dmi_access(input logic [6:0] addr, input logic we, input logic [31:0] wdata,
                             input int gnt_at, input int rv_after, input logic [31:0] core_rd);
      int cyc, req_idx, gnt_cyc;
      bit done;
      exp_q.push_back(model_access(addr, we, wdata, gnt_at, rv_after, core_rd));
      dmi_valid_i = 1'b1; dmi_addr_i = addr; dmi_write_en_i = we; dmi_wdata_i = wdata;
      debug_rdata_i = core_rd;
      cyc = 0; req_idx = 0; gnt_cyc = -1; done = 1'b0;
      while (!done && cyc < 400) begin
         // Core responder: reacts to the request it sees this cycle.
         if (debug_req_o) req_idx++;
         debug_gnt_i = debug_req_o && (req_idx == gnt_at);
         if (debug_gnt_i) gnt_cyc = cyc;
         debug_rvalid_i = (gnt_cyc >= 0) && (rv_after > 0) && (cyc == gnt_cyc + rv_after);
         @(negedge clk);
         done = dmi_ready_o;
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) begin
         check("dmi_timeout", 32'h0, 32'h1);
         void'(exp_q.pop_front());
      end
      dmi_valid_i = 1'b0; debug_gnt_i = 1'b0; debug_rvalid_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, {31'h0, dmi_ready_o}, 32'h0);
      check({tag, "_rdata"}, dmi_rdata_o, 32'h0);
      check({tag, "_req"}, {31'h0, debug_req_o}, 32'h0);
      check({tag, "_addr"}, {17'h0, debug_addr_o}, 32'h0);
      check({tag, "_we"}, {31'h0, debug_we_o}, 32'h0);
      check({tag, "_wdata"}, debug_wdata_o, 32'h0);
      check({tag, "_halt"}, {31'h0, debug_halt_o}, 32'h0);
      check({tag, "_resume"}, {31'h0, debug_resume_o}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // dmstatus while inactive
      dmi_access(A_STAT, 1'b0, 32'h0, 0, 0, 32'h0);
      check("dmstatus_running_lit", last_rdata, 32'h0000_0882);
      check("dmstatus_latency_lit", 32'(last_lat), 32'd1);
      debug_halted_i = 1'b1;
      dmi_access(A_STAT, 1'b0, 32'h0, 0, 0, 32'h0);
      check("dmstatus_halted_lit", last_rdata, 32'h0000_0282);
      debug_halted_i = 1'b0;

      // inactive: dbgaddr not writable, reads 0, dbgdata does nothing
      dmi_access(A_ADDR, 1'b1, 32'h0000_1234, 0, 0, 32'h0);
      dmi_access(A_ADDR, 1'b0, 32'h0, 0, 0, 32'h0);
      dmi_access(A_DATA, 1'b0, 32'h0, 1, 1, 32'h1111_1111);

      // run control
      dmi_access(A_CTRL, 1'b1, 32'h8000_0001, 0, 0, 32'h0);
      check("halt_pulse_lit", 32'(last_halt), 32'd1);
      dmi_access(A_CTRL, 1'b1, 32'h4000_0001, 0, 0, 32'h0);
      check("resume_pulse_lit", 32'(last_resume), 32'd1);
      dmi_access(A_CTRL, 1'b1, 32'hC000_0001, 0, 0, 32'h0);
      dmi_access(A_CTRL, 1'b0, 32'h0, 0, 0, 32'h0);

      // dbgaddr keeps low 15 bits
      dmi_access(A_ADDR, 1'b1, 32'hFFFF_2000, 0, 0, 32'h0);
      dmi_access(A_ADDR, 1'b0, 32'h0, 0, 0, 32'h0);
      check("dbgaddr_lit", last_rdata, 32'h0000_2000);

      // core read: gnt on 4th req cycle, rvalid 2 cycles later
      dmi_access(A_DATA, 1'b0, 32'h0, 4, 2, 32'hDEAD_BEEF);
      check("core_read_rdata_lit", last_rdata, 32'hDEAD_BEEF);
      check("core_read_req_lit", 32'(last_req), 32'd4);
      check("core_read_lat_lit", 32'(last_lat), 32'd7);
      dmi_access(A_DATA, 1'b1, 32'h1234_5678, 1, 1, 32'hFFFF_FFFF);

      // grant timeout, then err blocks dbgdata until W1C
      dmi_access(A_DATA, 1'b0, 32'h0, 0, 0, 32'h5555_5555);
      check("gnt_timeout_lat_lit", 32'(last_lat), 32'(TO + 1));
      dmi_access(A_CS, 1'b0, 32'h0, 0, 0, 32'h0);
      check("err_set_lit", last_rdata, 32'h0000_1000);
      dmi_access(A_DATA, 1'b0, 32'h0, 1, 1, 32'h7777_7777);
      dmi_access(A_CS, 1'b1, 32'h0000_1000, 0, 0, 32'h0);
      dmi_access(A_CS, 1'b0, 32'h0, 0, 0, 32'h0);

      // events in the abort cycle still succeed
      dmi_access(A_DATA, 1'b0, 32'h0, TO, TO, 32'hA5A5_0001);
      // rvalid one cycle too late: timeout in WAIT, late rvalid lands in RESP
      dmi_access(A_DATA, 1'b0, 32'h0, 2, TO + 1, 32'hA5A5_0002);
      dmi_access(A_CS, 1'b1, 32'h0000_1000, 0, 0, 32'h0);

      // unmapped address
      dmi_access(7'h05, 1'b1, 32'hFFFF_FFFF, 0, 0, 32'h0);
      dmi_access(7'h05, 1'b0, 32'h0, 0, 0, 32'h0);

      // deactivate clears dbgaddr and err
      dmi_access(A_DATA, 1'b0, 32'h0, 0, 0, 32'h0);
      dmi_access(A_CTRL, 1'b1, 32'h0000_0000, 0, 0, 32'h0);
      dmi_access(A_CTRL, 1'b1, 32'h0000_0001, 0, 0, 32'h0);
      dmi_access(A_CS, 1'b0, 32'h0, 0, 0, 32'h0);
      dmi_access(A_ADDR, 1'b0, 32'h0, 0, 0, 32'h0);

      // address wrap (with autoincrement) or fixed address (without)
      dmi_access(A_ADDR, 1'b1, 32'h0000_7FFC, 0, 0, 32'h0);
      dmi_access(A_DATA, 1'b1, 32'hCAFE_0001, 1, 1, 32'h0);
      dmi_access(A_DATA, 1'b1, 32'hCAFE_0002, 2, 1, 32'h0);
      dmi_access(A_ADDR, 1'b0, 32'h0, 0, 0, 32'h0);
`ifdef DM_AUTOINC_EN
      check("autoinc_wrap_lit", last_rdata, 32'h0000_0004);
`else
      check("no_autoinc_lit", last_rdata, 32'h0000_7FFC);
`endif

      // reset while waiting for rvalid; a late rvalid must not complete anything
      dmi_valid_i = 1'b1; dmi_addr_i = A_DATA; dmi_write_en_i = 1'b0;
      @(posedge clk); #1;          // REQ
      debug_gnt_i = debug_req_o;
      @(posedge clk); #1;          // WAIT
      debug_gnt_i = 1'b0;
      @(posedge clk); #1;          // still WAIT
      rst_n = 1'b0; dmi_valid_i = 1'b0;
      m_act = 1'b0; m_err = 1'b0; m_dbgaddr = 32'h0;
      @(posedge clk); #1;
      @(negedge clk);
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1; debug_rvalid_i = 1'b1; debug_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk);
      check("late_rvalid_ready0", {31'h0, dmi_ready_o}, 32'h0);
      @(posedge clk); #1;
      debug_rvalid_i = 1'b0;
      @(negedge clk);
      check("late_rvalid_ready1", {31'h0, dmi_ready_o}, 32'h0);
      @(posedge clk); #1;
      dmi_access(A_CTRL, 1'b0, 32'h0, 0, 0, 32'h0);
      dmi_access(A_STAT, 1'b0, 32'h0, 0, 0, 32'h0);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
